axil_mem_slave: RTL

AXI4-Lite memory slave that terminates the AXI path inside `chip`, directly downstream of the passthrough AXI VIP. It serves single-beat reads and byte-strobed writes from an internal word-addressed array. The array gives the passthrough and passive-slave monitors real RTL responses to scoreboard against, instead of relying only on the VIP memory model. Only one transaction is in service at a time; write address and write data are buffered independently.

---
 rtl/axil_mem_slave.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: one transaction in service, independent AW/W buffers, byte-strobed writes.
// Optional feature: define AXIL_MEM_SLAVE_RANGE_ERR_EN to answer out-of-range addresses with SLVERR.

module axil_mem_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_DATA} state_e;

    state_e                  state_q, state_d;
    logic                    aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic                    w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]       w_strb_q, w_strb_d;
    logic                    grant_rd_q, grant_rd_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic                    idle;
    logic                    pair_full;
    logic                    write_go;
    logic                    read_go;
    logic                    mem_we;
    logic                    aw_oor;
    logic                    ar_oor;
    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        ar_idx;
    logic                    unused_bits;

    assign aw_idx = aw_addr_q[OFF +: IDX_W];
    assign ar_idx = araddr[OFF +: IDX_W];

`ifdef AXIL_MEM_SLAVE_RANGE_ERR_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS * STRB_W);
    assign aw_oor = ({1'b0, aw_addr_q} >= LIMIT);
    assign ar_oor = ({1'b0, araddr} >= LIMIT);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Protection bits and the address bits outside the word index carry no meaning here.
    assign unused_bits = ^{awprot, arprot, aw_addr_q, araddr};

    assign idle      = (state_q == IDLE);
    assign pair_full = aw_full_q && w_full_q;
    assign write_go  = idle && pair_full && (!grant_rd_q || !arvalid);
    assign arready   = idle && !(pair_full && !grant_rd_q);
    assign read_go   = arvalid && arready;
    assign mem_we    = write_go && !aw_oor;

    assign awready = !aw_full_q;
    assign wready  = !w_full_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    always_comb begin
        state_d    = state_q;
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        grant_rd_d = grant_rd_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        if (awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        // A contest flips the grant so write and read take turns.
        if (idle && pair_full && arvalid) begin
            grant_rd_d = !grant_rd_q;
        end

        unique case (state_q)
            IDLE: begin
                if (write_go) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = aw_oor ? RESP_SLVERR : RESP_OKAY;
                    state_d   = WR_RESP;
                end else if (read_go) begin
                    rvalid_d = 1'b1;
                    rresp_d  = ar_oor ? RESP_SLVERR : RESP_OKAY;
                    rdata_d  = ar_oor ? '0 : mem[ar_idx];
                    state_d  = RD_DATA;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            grant_rd_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            grant_rd_q <= grant_rd_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array contents survive reset; only the write port is gated by it.
    always_ff @(posedge aclk) begin
        if (aresetn && mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) begin
                    mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

endmodule
